// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_chunk_adder
//  Purpose  : Multi-cycle adder. Two WIDTH-bit operands are added CHUNK bits
//             per clock, and the carry ripples between chunks through a
//             register. The result is valid NCHUNK = WIDTH/CHUNK clocks after
//             the accept edge. Valid/ready handshakes on both sides.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             in_valid/in_ready   operand handshake (ready only in IDLE)
//             a, b, cin           operands and carry-in, latched on accept
//             sub                 subtract request (ADDER_SUB_EN builds only)
//             out_valid/out_ready result handshake (valid only in DONE)
//             sum, carry          result; held from DONE until next accept
//             busy                high while chunks are being added
//  Config   : `define ADDER_SUB_EN adds the sub port. sub=1 at accept latches
//             ~b with carry-in 1, giving a-b. carry=1 then means no borrow.
//  Revision : 1.0  initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic [CHUNK:0]   w_chunk;

    // Operand conditioning at the accept edge: subtraction is a + ~b + 1.
`ifdef ADDER_SUB_EN
    assign w_b_in   = sub ? ~b   : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == C_LAST_CNT);

    // One CHUNK-wide slice sum; the extra MSB is the carry into the next slice.
    assign w_chunk = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]}
                   + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(r_carry);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_sum[r_cnt*CHUNK +: CHUNK] <= w_chunk[CHUNK-1:0];
            r_carry                     <= w_chunk[CHUNK];
            // Park the counter at zero after the last slice so it never
            // points past the top of the operands.
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // After the last slice r_carry holds bit WIDTH of the full sum and is
    // left untouched until the next accept.
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_chunk_adder
//  Purpose  : Self-checking bench. Four adders (CHUNK = 2, 1, 4, 8 at
//             WIDTH = 8) share one stimulus stream. Each one is checked for
//             result and latency against hand-computed vectors and an
//             integer reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_chunk_adder;

    localparam int NI = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       rdy [NI];
    logic       ov  [NI];
    logic [7:0] sm  [NI];
    logic       cy  [NI];
    logic       bz  [NI];

    int checks;
    int errors;
    int lat_exp [NI];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
    } vec_t;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .carry(cy[0]),
        .busy(bz[0]));

    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .carry(cy[1]),
        .busy(bz[1]));

    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .carry(cy[2]),
        .busy(bz[2]));

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[3]), .out_ready(out_ready), .sum(sm[3]), .carry(cy[3]),
        .busy(bz[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) until every instance is back in IDLE.
    task automatic wait_idle(input string nm);
        bit all;
        for (int t = 0; t < 40; t++) begin
            all = 1'b1;
            for (int i = 0; i < NI; i++) if (rdy[i] !== 1'b1) all = 1'b0;
            if (all) return;
            @(posedge clk); #1;
        end
        chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    // One transaction on all instances; checks sum, carry and latency of each.
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_b,
                           input logic tcin, input logic tsub,
                           input logic [7:0] es, input logic ec, input string nm);
        int         lat  [NI];
        logic [7:0] gs   [NI];
        logic       gc   [NI];
        bit         seen [NI];
        int         n;
        wait_idle(nm);
        a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        // Operands are free to change once accepted.
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < NI; i++) begin
            seen[i] = 1'b0; lat[i] = 0; gs[i] = 8'h00; gc[i] = 1'b0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            n = 0;
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && ov[i] === 1'b1) begin
                    seen[i] = 1'b1; lat[i] = cyc; gs[i] = sm[i]; gc[i] = cy[i];
                end
                if (seen[i]) n++;
            end
            if (n == NI) break;
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_sum_i%0d", nm, i), 32'(gs[i]), 32'(es));
            chk($sformatf("%s_carry_i%0d", nm, i), 32'(gc[i]), 32'(ec));
            chk($sformatf("%s_lat_i%0d", nm, i), 32'(lat[i]), 32'(lat_exp[i]));
        end
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] full;

        checks = 0; errors = 0;
        lat_exp = '{4, 8, 2, 1};
        vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sum", 32'(sm[0]), 32'h0);
        chk("reset_carry", 32'(cy[0]), 32'h0);
        chk("reset_out_valid", 32'(ov[0]), 32'h0);
        chk("reset_busy", 32'(bz[0]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 32'(rdy[0]), 32'h1);

        // Directed table
        for (int v = 0; v < 7; v++)
            run_add(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub,
                    vecs[v].s, vecs[v].c, $sformatf("vec%0d", v));

        // Result held in DONE while consumer stalls; in_valid ignored
        wait_idle("hold");
        out_ready = 1'b0;
        a = 8'h5C; b = 8'h3B; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int t = 0; t < 20 && ov[0] !== 1'b1; t++) begin
            @(posedge clk); #1;
        end
        for (int t = 0; t < 10; t++) begin
            chk($sformatf("hold_out_valid_t%0d", t), 32'(ov[0]), 32'h1);
            chk($sformatf("hold_sum_t%0d", t), 32'(sm[0]), 32'h97);
            chk($sformatf("hold_carry_t%0d", t), 32'(cy[0]), 32'h0);
            chk($sformatf("hold_in_ready_t%0d", t), 32'(rdy[0]), 32'h0);
            if (t == 3) begin a = 8'h01; b = 8'h01; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_in_ready", 32'(rdy[0]), 32'h1);
        chk("hold_release_out_valid", 32'(ov[0]), 32'h0);
        chk("hold_release_sum_kept", 32'(sm[0]), 32'h97);

        // Abort mid-BUSY with reset
        wait_idle("abort");
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", 32'(bz[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(sm[0]), 32'h0);
        chk("abort_carry", 32'(cy[0]), 32'h0);
        chk("abort_busy", 32'(bz[0]), 32'h0);
        chk("abort_out_valid", 32'(ov[0]), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 32'(rdy[0]), 32'h1);
        run_add(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "after_abort");

`ifdef ADDER_SUB_EN
        run_add(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, "sub_borrow");
        run_add(8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, "sub_noborrow");
`endif

        // Random sweep against an integer reference
        for (int r = 0; r < 200; r++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run_add(ra, rb, rc, 1'b0, full[7:0], full[8], $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
